// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and baud defaults shared by the UART TX and RX blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLKS_PER_BIT = 104;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchroniser with a configurable reset value
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver presenting each byte on a single-entry valid/ready output
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_en,
  input  logic                  ftdi_rx,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] shift;
  logic rxs;
  uart_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(ftdi_rx), .q(rxs));
  // LSB arrives first, so shifting in from the top leaves bit 0 in place after the last sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_HIGH;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (!rx_en) state <= WAIT_HIGH;
      else
        case (state)
          WAIT_HIGH: if (rxs) state <= IDLE;
          IDLE: if (!rxs) begin
            state <= START;
            cnt <= '0;
          end
          START: if (cnt == HALF_LAST) begin
            state <= rxs ? IDLE : DATA;
            cnt <= '0;
            idx <= '0;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == BIT_LAST) begin
            shift <= {rxs, shift[DATA_WIDTH-1:1]};
            cnt <= '0;
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state <= WAIT_HIGH;
            end else begin
              state <= IDLE;
              if (rx_valid && !rx_ready) overrun_err <= 1'b1;
              else begin
                rx_byte <= shift;
                rx_valid <= 1'b1;
              end
            end
          end else cnt <= cnt + 1'b1;
          default: state <= WAIT_HIGH;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a behavioural receiver model
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  localparam int DW = 8;
  localparam int LAT = 3 + HALF + (DW + 1) * CPB;
  logic clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, ftdi_rx = 1'b1, rx_ready = 1'b0;
  logic [DW-1:0] rx_byte;
  logic rx_valid, frame_err, overrun_err;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, rise_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [DW-1:0] exp_byte = '0;
  logic exp_valid = 1'b0;
  int exp_fe = 0, exp_ov = 0;

  uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .ftdi_rx(ftdi_rx), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (frame_err && overrun_err) both_cnt++;
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic v, int n);
    ftdi_rx = v;
    step(n);
  endtask

  task automatic send(logic [DW-1:0] b);
    drive(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive(b[i], CPB);
    drive(1'b1, CPB);
  endtask

  // A good frame either fills the empty/consumed slot or is dropped as an overrun
  task automatic model_good(logic [DW-1:0] b, logic ready_at_end);
    if (exp_valid && !ready_at_end) exp_ov++;
    else begin
      exp_byte = b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic handshake();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic check_model(string tag);
    check({tag, "_byte"}, 32'(rx_byte), 32'(exp_byte));
    check({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_ov"}, ov_cnt, exp_ov);
  endtask

  initial begin
    int k, r0;
    logic [DW-1:0] b;
    step(3);
    check("rst_byte", 32'(rx_byte), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_ov", 32'(overrun_err), 0);
    check("rst_state", 32'(dut.state), 32'(WAIT_HIGH));
    rst_n = 1'b1;
    rx_en = 1'b1;
    step(4);
    check("armed_state", 32'(dut.state), 32'(IDLE));

    k = cyc;
    r0 = rise_cnt;
    send(8'h47);
    model_good(8'h47, 1'b0);
    check("f47_rise", rise_cnt, r0 + 1);
    check("f47_latency", rise_cyc - k, LAT);
    step(20);
    check_model("f47_held");
    handshake();
    check_model("f47_consumed");

    r0 = rise_cnt;
    drive(1'b0, 4);
    drive(1'b1, 30);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_rise", rise_cnt, r0);
    check_model("glitch");
    send(8'hA5);
    model_good(8'hA5, 1'b0);
    check_model("fa5");
    handshake();

    r0 = rise_cnt;
    drive(1'b0, 12 * CPB);
    exp_fe++;
    check("break_state", 32'(dut.state), 32'(WAIT_HIGH));
    check("break_rise", rise_cnt, r0);
    check_model("break");
    drive(1'b1, CPB);
    check("break_rearm", 32'(dut.state), 32'(IDLE));
    send(8'h3C);
    model_good(8'h3C, 1'b0);
    check_model("f3c");
    handshake();

    send(8'h33);
    model_good(8'h33, 1'b0);
    send(8'hA5);
    model_good(8'hA5, 1'b0);
    step(2);
    check_model("overrun");
    handshake();
    send(8'h33);
    model_good(8'h33, 1'b0);
    fork
      send(8'hA5);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    model_good(8'hA5, 1'b1);
    check_model("same_cycle_hs");

    b = 8'h5A;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(b[i], CPB);
    drive(b[4], CPB / 2);
    #2 rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_byte = '0;
    check("async_rst_byte", 32'(rx_byte), 0);
    check("async_rst_valid", 32'(rx_valid), 0);
    check("async_rst_errs", 32'({frame_err, overrun_err}), 0);
    ftdi_rx = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(4);
    send(8'h5A);
    model_good(8'h5A, 1'b0);
    check_model("f5a");

    b = 8'($urandom);
    r0 = rise_cnt;
    drive(1'b0, CPB);
    drive(b[0], CPB);
    drive(b[1], CPB);
    drive(b[2], CPB / 2);
    rx_en = 1'b0;
    step(1);
    check("en_low_state", 32'(dut.state), 32'(WAIT_HIGH));
    handshake();
    check_model("en_low_hs");
    drive(b[2], CPB / 2);
    for (int i = 3; i < DW; i++) drive(b[i], CPB);
    drive(1'b1, 2 * CPB);
    rx_en = 1'b1;
    step(4);
    check("en_drop_rise", rise_cnt, r0);
    check_model("en_drop");
    send(8'hFF);
    model_good(8'hFF, 1'b0);
    check_model("fff");
    handshake();

    for (int n = 0; n < 10; n++) begin
      drive(1'b1, $urandom_range(0, 3));
      b = 8'($urandom);
      send(b);
      model_good(b, 1'b0);
      check_model($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) handshake();
    end

    check("errs_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
